miriscv_memory_stage: RTL and testbench

Memory stage of the miriscv pipeline, between Execute and Writeback. Consumes the Execute pipeline register, issues load/store transactions on the data bus with a req/gnt/rvalid handshake, and aligns and extends load data. Selects the writeback value (ALU, MDU or LSU) and registers it for Writeback. Requests a pipeline stall while a data access is outstanding.

---
 rtl/miriscv_decode_pkg.sv | 19 +
 rtl/miriscv_lsu_pkg.sv | 26 ++
 rtl/miriscv_lsu.sv | 188 ++++++++++++++++++
 rtl/miriscv_memory_stage.sv | 123 ++++++++++++
 tb/tb_miriscv_memory_stage.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/miriscv_decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : miriscv_decode_pkg
//  Purpose  : Datapath widths and writeback-source encodings shared by the
//             decode and later pipeline stages.
//  Revision : 1.0  initial release
// ============================================================================
package miriscv_decode_pkg;

    localparam int XLEN       = 32;
    localparam int GPR_ADDR_W = 5;
    localparam int WB_SRC_W   = 2;

    localparam logic [WB_SRC_W-1:0] ALU_DATA = 2'd0;
    localparam logic [WB_SRC_W-1:0] MDU_DATA = 2'd1;
    localparam logic [WB_SRC_W-1:0] LSU_DATA = 2'd2;

endpackage : miriscv_decode_pkg
`default_nettype wire

// File: rtl/miriscv_lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : miriscv_lsu_pkg
//  Purpose  : Load/store unit definitions: access size/sign codes and the
//             bus-transaction FSM state type.
//  Revision : 1.0  initial release
// ============================================================================
package miriscv_lsu_pkg;

    localparam int MEM_ACCESS_W = 3;

    // Bit 2 selects zero-extension for loads; bits [1:0] give the size.
    localparam logic [MEM_ACCESS_W-1:0] SIZE_BYTE   = 3'b000;
    localparam logic [MEM_ACCESS_W-1:0] SIZE_HALF   = 3'b001;
    localparam logic [MEM_ACCESS_W-1:0] SIZE_WORD   = 3'b010;
    localparam logic [MEM_ACCESS_W-1:0] SIZE_BYTE_U = 3'b100;
    localparam logic [MEM_ACCESS_W-1:0] SIZE_HALF_U = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } lsu_state_e;

endpackage : miriscv_lsu_pkg
`default_nettype wire

// File: rtl/miriscv_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : miriscv_lsu
//  Purpose  : Data-bus master for the memory stage. Issues one req/gnt/rvalid
//             transaction per load/store, builds byte enables and replicated
//             store data, aligns/extends load data and keeps a response that
//             arrived while the stage was held.
//  Ports    : clk_i, arstn_i         clock, async active-low reset
//             valid_i, mem_*_i       access from the Execute register
//             stall_i, kill_i        stage hold / flush from control unit
//             data_*                 data bus master side
//             rdata_o                aligned and extended load data
//             misaligned_o           access request is misaligned (comb.)
//             stall_req_o            access outstanding (comb.)
//  Revision : 1.0  initial release
// ============================================================================
module miriscv_lsu
    import miriscv_lsu_pkg::*;
    import miriscv_decode_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    arstn_i,
    input  logic                    valid_i,
    input  logic                    mem_req_i,
    input  logic                    mem_we_i,
    input  logic [MEM_ACCESS_W-1:0] mem_size_i,
    input  logic [XLEN-1:0]         mem_addr_i,
    input  logic [XLEN-1:0]         mem_data_i,
    input  logic                    stall_i,
    input  logic                    kill_i,
    output logic                    data_req_o,
    output logic                    data_we_o,
    output logic [XLEN/8-1:0]       data_be_o,
    output logic [XLEN-1:0]         data_addr_o,
    output logic [XLEN-1:0]         data_wdata_o,
    input  logic                    data_gnt_i,
    input  logic                    data_rvalid_i,
    input  logic [XLEN-1:0]         data_rdata_i,
    output logic [XLEN-1:0]         rdata_o,
    output logic                    misaligned_o,
    output logic                    stall_req_o
);

    lsu_state_e          r_state;
    lsu_state_e          w_next_state;
    logic [1:0]          w_offset;
    logic                w_misaligned;
    logic                w_issue;
    logic [XLEN/8-1:0]   w_be;
    logic [XLEN-1:0]     w_wdata;
    logic [XLEN-1:0]     w_raw;
    logic [XLEN-1:0]     w_shifted;
    logic                r_done;
    logic [XLEN-1:0]     r_hold;
    logic                r_we;
    logic [XLEN/8-1:0]   r_be;
    logic [XLEN-1:0]     r_addr;
    logic [XLEN-1:0]     r_wdata;

    assign w_offset = mem_addr_i[1:0];

    always_comb begin
        case (mem_size_i)
            SIZE_HALF, SIZE_HALF_U: w_misaligned = w_offset[0];
            SIZE_WORD:              w_misaligned = |w_offset;
            default:                w_misaligned = 1'b0;
        endcase
    end

    assign misaligned_o = mem_req_i & w_misaligned;
    // r_done blocks a second transaction for an access already answered.
    assign w_issue      = valid_i & mem_req_i & ~w_misaligned & ~r_done;

    always_comb begin
        case (mem_size_i[1:0])
            2'b00: begin
                w_be    = 4'b0001 << w_offset;
                w_wdata = {4{mem_data_i[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << w_offset;
                w_wdata = {2{mem_data_i[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = mem_data_i;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        data_req_o   = 1'b0;
        data_we_o    = 1'b0;
        data_be_o    = '0;
        data_addr_o  = '0;
        data_wdata_o = '0;
        stall_req_o  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_issue) begin
                    data_req_o   = 1'b1;
                    data_we_o    = mem_we_i;
                    data_be_o    = w_be;
                    data_addr_o  = {mem_addr_i[XLEN-1:2], 2'b00};
                    data_wdata_o = w_wdata;
                    stall_req_o  = 1'b1;
                    w_next_state = data_gnt_i ? RSP : REQ;
                end
            end
            REQ: begin
                // Driven from the captured copy so the request stays stable
                // even if the upstream register changes underneath it.
                data_req_o   = 1'b1;
                data_we_o    = r_we;
                data_be_o    = r_be;
                data_addr_o  = r_addr;
                data_wdata_o = r_wdata;
                stall_req_o  = 1'b1;
                if (data_gnt_i) begin
                    w_next_state = RSP;
                end
            end
            RSP: begin
                stall_req_o = ~data_rvalid_i;
                if (data_rvalid_i) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_we    <= 1'b0;
            r_be    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if ((r_state == IDLE) && w_issue) begin
            r_we    <= mem_we_i;
            r_be    <= w_be;
            r_addr  <= {mem_addr_i[XLEN-1:2], 2'b00};
            r_wdata <= w_wdata;
        end
    end

    // A response that lands while the stage is held is parked here until
    // the stage advances.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_done <= 1'b0;
            r_hold <= '0;
        end else begin
            if (kill_i || !stall_i) begin
                r_done <= 1'b0;
            end else if ((r_state == RSP) && data_rvalid_i) begin
                r_done <= 1'b1;
            end
            if ((r_state == RSP) && data_rvalid_i && stall_i) begin
                r_hold <= data_rdata_i;
            end
        end
    end

    assign w_raw     = r_done ? r_hold : data_rdata_i;
    assign w_shifted = w_raw >> {w_offset, 3'b000};

    always_comb begin
        case (mem_size_i)
            SIZE_BYTE:   rdata_o = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
            SIZE_HALF:   rdata_o = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            SIZE_BYTE_U: rdata_o = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
            SIZE_HALF_U: rdata_o = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
            default:     rdata_o = w_shifted;
        endcase
    end

endmodule : miriscv_lsu
`default_nettype wire

// File: rtl/miriscv_memory_stage.sv
`default_nettype none
// ============================================================================
//  Module   : miriscv_memory_stage
//  Purpose  : Memory stage of the miriscv pipeline. Runs loads/stores through
//             the LSU, selects the writeback value and registers it for
//             Writeback. Requests a stall while a data access is outstanding.
//  Ports    : clk_i, arstn_i                 clock, async active-low reset
//             cu_kill_m_i, cu_stall_m_i      flush / hold from control unit
//             m_stall_req_o                  stall request (comb.)
//             e_*                            Execute pipeline register
//             data_*                         data bus master side
//             m_*                            M pipeline register outputs
//  Revision : 1.0  initial release
// ============================================================================
module miriscv_memory_stage
    import miriscv_lsu_pkg::*;
    import miriscv_decode_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    arstn_i,
    input  logic                    cu_kill_m_i,
    input  logic                    cu_stall_m_i,
    output logic                    m_stall_req_o,
    input  logic                    e_valid_i,
    input  logic [XLEN-1:0]         e_alu_result_i,
    input  logic [XLEN-1:0]         e_mdu_result_i,
    input  logic                    e_mem_req_i,
    input  logic                    e_mem_we_i,
    input  logic [MEM_ACCESS_W-1:0] e_mem_size_i,
    input  logic [XLEN-1:0]         e_mem_addr_i,
    input  logic [XLEN-1:0]         e_mem_data_i,
    input  logic                    e_gpr_wr_en_i,
    input  logic [GPR_ADDR_W-1:0]   e_gpr_wr_addr_i,
    input  logic [WB_SRC_W-1:0]     e_gpr_src_sel_i,
    output logic                    data_req_o,
    output logic                    data_we_o,
    output logic [XLEN/8-1:0]       data_be_o,
    output logic [XLEN-1:0]         data_addr_o,
    output logic [XLEN-1:0]         data_wdata_o,
    input  logic                    data_gnt_i,
    input  logic                    data_rvalid_i,
    input  logic [XLEN-1:0]         data_rdata_i,
    output logic                    m_valid_o,
    output logic                    m_gpr_wr_en_o,
    output logic [GPR_ADDR_W-1:0]   m_gpr_wr_addr_o,
    output logic [XLEN-1:0]         m_gpr_wr_data_o,
    output logic                    m_misaligned_o
);

    logic            r_killed;
    logic            w_valid;
    logic            w_lsu_misaligned;
    logic [XLEN-1:0] w_lsu_rdata;
    logic [XLEN-1:0] w_wb_data;

    // A kill that arrives while the stage is held must survive until the
    // instruction finally leaves, otherwise it would re-enter M as valid.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_killed <= 1'b0;
        end else if (cu_kill_m_i && cu_stall_m_i) begin
            r_killed <= 1'b1;
        end else if (!cu_stall_m_i) begin
            r_killed <= 1'b0;
        end
    end

    assign w_valid = e_valid_i & ~r_killed;

    miriscv_lsu u_lsu (
        .clk_i         (clk_i),
        .arstn_i       (arstn_i),
        .valid_i       (w_valid & ~cu_kill_m_i),
        .mem_req_i     (e_mem_req_i),
        .mem_we_i      (e_mem_we_i),
        .mem_size_i    (e_mem_size_i),
        .mem_addr_i    (e_mem_addr_i),
        .mem_data_i    (e_mem_data_i),
        .stall_i       (cu_stall_m_i),
        .kill_i        (cu_kill_m_i),
        .data_req_o    (data_req_o),
        .data_we_o     (data_we_o),
        .data_be_o     (data_be_o),
        .data_addr_o   (data_addr_o),
        .data_wdata_o  (data_wdata_o),
        .data_gnt_i    (data_gnt_i),
        .data_rvalid_i (data_rvalid_i),
        .data_rdata_i  (data_rdata_i),
        .rdata_o       (w_lsu_rdata),
        .misaligned_o  (w_lsu_misaligned),
        .stall_req_o   (m_stall_req_o)
    );

    always_comb begin
        case (e_gpr_src_sel_i)
            MDU_DATA: w_wb_data = e_mdu_result_i;
            LSU_DATA: w_wb_data = w_lsu_rdata;
            default:  w_wb_data = e_alu_result_i;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            m_valid_o       <= 1'b0;
            m_gpr_wr_en_o   <= 1'b0;
            m_gpr_wr_addr_o <= '0;
            m_gpr_wr_data_o <= '0;
            m_misaligned_o  <= 1'b0;
        end else if (cu_kill_m_i) begin
            m_valid_o       <= 1'b0;
            m_gpr_wr_en_o   <= 1'b0;
            m_misaligned_o  <= 1'b0;
        end else if (!cu_stall_m_i) begin
            m_valid_o       <= w_valid;
            m_gpr_wr_en_o   <= w_valid & e_gpr_wr_en_i & ~w_lsu_misaligned;
            m_gpr_wr_addr_o <= e_gpr_wr_addr_i;
            m_gpr_wr_data_o <= w_wb_data;
            m_misaligned_o  <= w_valid & w_lsu_misaligned;
        end
    end

endmodule : miriscv_memory_stage
`default_nettype wire

// File: tb/tb_miriscv_memory_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_miriscv_memory_stage
//  Purpose  : Self-checking bench for the memory stage: directed cases plus
//             randomized instruction stream against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_miriscv_memory_stage;
    import miriscv_lsu_pkg::*;
    import miriscv_decode_pkg::*;

    logic        clk;
    logic        arstn;
    logic        cu_kill_m_i;
    logic        cu_stall_m_i;
    logic        ext_stall;
    logic        m_stall_req_o;
    logic        e_valid_i;
    logic [31:0] e_alu_result_i, e_mdu_result_i;
    logic        e_mem_req_i, e_mem_we_i;
    logic [2:0]  e_mem_size_i;
    logic [31:0] e_mem_addr_i, e_mem_data_i;
    logic        e_gpr_wr_en_i;
    logic [4:0]  e_gpr_wr_addr_i;
    logic [1:0]  e_gpr_src_sel_i;
    logic        data_req_o, data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o, data_wdata_o;
    logic        data_gnt_i, data_rvalid_i;
    logic [31:0] data_rdata_i;
    logic        m_valid_o, m_gpr_wr_en_o;
    logic [4:0]  m_gpr_wr_addr_o;
    logic [31:0] m_gpr_wr_data_o;
    logic        m_misaligned_o;

    int n_total = 0;
    int n_bad   = 0;

    // Control-unit model: hold M while the stage asks, or on an external hold.
    assign cu_stall_m_i = m_stall_req_o | ext_stall;

    miriscv_memory_stage dut (
        .clk_i           (clk),
        .arstn_i         (arstn),
        .cu_kill_m_i     (cu_kill_m_i),
        .cu_stall_m_i    (cu_stall_m_i),
        .m_stall_req_o   (m_stall_req_o),
        .e_valid_i       (e_valid_i),
        .e_alu_result_i  (e_alu_result_i),
        .e_mdu_result_i  (e_mdu_result_i),
        .e_mem_req_i     (e_mem_req_i),
        .e_mem_we_i      (e_mem_we_i),
        .e_mem_size_i    (e_mem_size_i),
        .e_mem_addr_i    (e_mem_addr_i),
        .e_mem_data_i    (e_mem_data_i),
        .e_gpr_wr_en_i   (e_gpr_wr_en_i),
        .e_gpr_wr_addr_i (e_gpr_wr_addr_i),
        .e_gpr_src_sel_i (e_gpr_src_sel_i),
        .data_req_o      (data_req_o),
        .data_we_o       (data_we_o),
        .data_be_o       (data_be_o),
        .data_addr_o     (data_addr_o),
        .data_wdata_o    (data_wdata_o),
        .data_gnt_i      (data_gnt_i),
        .data_rvalid_i   (data_rvalid_i),
        .data_rdata_i    (data_rdata_i),
        .m_valid_o       (m_valid_o),
        .m_gpr_wr_en_o   (m_gpr_wr_en_o),
        .m_gpr_wr_addr_o (m_gpr_wr_addr_o),
        .m_gpr_wr_data_o (m_gpr_wr_data_o),
        .m_misaligned_o  (m_misaligned_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // kind: 0 ALU op, 1 MDU op, 2 load, 3 store
    typedef struct {
        bit          valid;
        int          kind;
        logic [2:0]  size;
        logic [31:0] addr, data, alu, mdu, rdata;
        logic [4:0]  rd;
        int          gdly, rdly, xstall, kill_at;
    } instr_t;

    // ---------------- reference model ----------------
    function automatic int unsigned size_bytes(input logic [2:0] sz);
        if (sz[1:0] == 2'b00) return 1;
        if (sz[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit ref_misaligned(input logic [2:0] sz, input logic [31:0] addr);
        return (addr % size_bytes(sz)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] sz, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        longint unsigned r, v, lim;
        int unsigned n, k;
        n   = size_bytes(sz);
        k   = addr % 4;
        r   = rdata;
        lim = 64'd1 << (8 * n);
        v   = (r >> (8 * k)) % lim;
        if (!sz[2] && n < 4 && v >= lim / 2) v = v + 64'h1_0000_0000 - lim;
        return v[31:0];
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] sz, input logic [31:0] addr);
        int unsigned v;
        v = ((1 << size_bytes(sz)) - 1) << (addr % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] sz, input logic [31:0] d);
        if (size_bytes(sz) == 1) return (d % 256) * 32'h0101_0101;
        if (size_bytes(sz) == 2) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    // ---------------- per-cycle bus / control drive ----------------
    task automatic drive_cycle(input instr_t t, input bit acc, input int tt, input int c);
        data_gnt_i    = acc && (c >= t.gdly);
        data_rvalid_i = acc && (c == tt);
        data_rdata_i  = (acc && c == tt) ? t.rdata : $urandom;
        ext_stall     = (c >= tt) && (c < tt + t.xstall);
        cu_kill_m_i   = (c == t.kill_at);
    endtask

    // Entered and left #1 after a rising edge.
    task automatic run(input instr_t t);
        bit          mem, mis, acc, fin, adv, exp_valid, exp_wen;
        int          tt, c, stall_cnt, req_cnt, hs, bad_bus;
        logic [31:0] exp_wb;
        mem = (t.kind >= 2);
        mis = mem && ref_misaligned(t.size, t.addr);
        acc = t.valid && mem && !mis;
        tt  = acc ? t.gdly + 1 + t.rdly : 0;
        e_valid_i       = t.valid;
        e_mem_req_i     = mem;
        e_mem_we_i      = (t.kind == 3);
        e_mem_size_i    = t.size;
        e_mem_addr_i    = t.addr;
        e_mem_data_i    = t.data;
        e_alu_result_i  = t.alu;
        e_mdu_result_i  = t.mdu;
        e_gpr_wr_en_i   = (t.kind != 3);
        e_gpr_wr_addr_i = t.rd;
        e_gpr_src_sel_i = (t.kind == 1) ? MDU_DATA : (t.kind == 2) ? LSU_DATA : ALU_DATA;
        stall_cnt = 0; req_cnt = 0; hs = 0; bad_bus = 0; c = 0; fin = 0;
        drive_cycle(t, acc, tt, 0);
        while (!fin && c < 60) begin
            @(negedge clk);
            if (data_req_o) begin
                req_cnt++;
                if (data_gnt_i) hs++;
                if (data_addr_o !== (t.addr & 32'hFFFF_FFFC) || data_be_o !== ref_be(t.size, t.addr)
                    || data_we_o !== (t.kind == 3)
                    || (t.kind == 3 && data_wdata_o !== ref_wdata(t.size, t.data)))
                    bad_bus++;
            end
            if (m_stall_req_o) stall_cnt++;
            adv = !cu_stall_m_i;
            @(posedge clk); #1;
            if (adv) fin = 1;
            else begin
                c++;
                drive_cycle(t, acc, tt, c);
            end
        end
        if (!fin) check_val("advance_timeout", 32'd1, 32'd0);
        check_val("stall_cycles", stall_cnt, acc ? tt : 0);
        check_val("req_cycles", req_cnt, acc ? t.gdly + 1 : 0);
        check_val("handshakes", hs, acc ? 1 : 0);
        check_val("bus_fields", bad_bus, 0);
        exp_valid = t.valid && (t.kill_at < 0);
        exp_wen   = exp_valid && (t.kind != 3) && !mis;
        case (t.kind)
            1:       exp_wb = t.mdu;
            2:       exp_wb = ref_load(t.size, t.addr, t.rdata);
            default: exp_wb = t.alu;
        endcase
        check_val("m_valid", {31'd0, m_valid_o}, {31'd0, exp_valid});
        check_val("m_misaligned", {31'd0, m_misaligned_o}, {31'd0, exp_valid && mis});
        check_val("m_wr_en", {31'd0, m_gpr_wr_en_o}, {31'd0, exp_wen});
        if (exp_wen) begin
            check_val("m_wr_addr", {27'd0, m_gpr_wr_addr_o}, {27'd0, t.rd});
            check_val("m_wr_data", m_gpr_wr_data_o, exp_wb);
        end
    endtask

    function automatic instr_t mk(input int kind, input logic [2:0] size, input logic [31:0] addr,
                                  input logic [31:0] data, input logic [31:0] rdata,
                                  input int gdly, input int rdly, input int xstall, input int kill_at);
        instr_t t;
        t.valid = 1; t.kind = kind; t.size = size; t.addr = addr; t.data = data;
        t.rdata = rdata; t.alu = $urandom; t.mdu = $urandom; t.rd = 5'($urandom_range(1, 31));
        t.gdly = gdly; t.rdly = rdly; t.xstall = xstall; t.kill_at = kill_at;
        return t;
    endfunction

    function automatic instr_t rand_instr();
        instr_t      t;
        int          kind;
        logic [2:0]  sz;
        logic [31:0] a;
        kind = $urandom_range(0, 3);
        case ($urandom_range(0, (kind == 3) ? 2 : 4))
            0:       sz = SIZE_BYTE;
            1:       sz = SIZE_HALF;
            2:       sz = SIZE_WORD;
            3:       sz = SIZE_BYTE_U;
            default: sz = SIZE_HALF_U;
        endcase
        a = $urandom;
        if ($urandom_range(0, 3) != 0) a = a - (a % size_bytes(sz));
        t = mk(kind, sz, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 2),
               ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0, -1);
        t.valid = ($urandom_range(0, 9) != 0);
        return t;
    endfunction

    initial begin
        instr_t t;
        arstn = 1'b0; ext_stall = 1'b0; cu_kill_m_i = 1'b0;
        e_valid_i = 1'b0; e_alu_result_i = '0; e_mdu_result_i = '0;
        e_mem_req_i = 1'b0; e_mem_we_i = 1'b0; e_mem_size_i = '0;
        e_mem_addr_i = '0; e_mem_data_i = '0; e_gpr_wr_en_i = 1'b0;
        e_gpr_wr_addr_i = '0; e_gpr_src_sel_i = '0;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0;
        repeat (2) @(negedge clk);
        check_val("rst_req", {31'd0, data_req_o}, 32'd0);
        check_val("rst_we", {31'd0, data_we_o}, 32'd0);
        check_val("rst_be", {28'd0, data_be_o}, 32'd0);
        check_val("rst_addr", data_addr_o, 32'd0);
        check_val("rst_wdata", data_wdata_o, 32'd0);
        check_val("rst_valid", {31'd0, m_valid_o}, 32'd0);
        check_val("rst_wr_en", {31'd0, m_gpr_wr_en_o}, 32'd0);
        check_val("rst_wr_addr", {27'd0, m_gpr_wr_addr_o}, 32'd0);
        check_val("rst_wr_data", m_gpr_wr_data_o, 32'd0);
        check_val("rst_misaligned", {31'd0, m_misaligned_o}, 32'd0);
        check_val("rst_stall", {31'd0, m_stall_req_o}, 32'd0);
        arstn = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        run(mk(3, SIZE_WORD, 32'h104, 32'hDEAD_BEEF, 32'h0, 0, 0, 0, -1));
        run(mk(2, SIZE_BYTE, 32'h103, 32'h0, 32'h80FF_FF00, 0, 0, 0, -1));
        check_val("lb_value", m_gpr_wr_data_o, 32'hFFFF_FF80);
        run(mk(2, SIZE_BYTE_U, 32'h103, 32'h0, 32'h80FF_FF00, 0, 0, 0, -1));
        check_val("lbu_value", m_gpr_wr_data_o, 32'h0000_0080);
        run(mk(2, SIZE_HALF_U, 32'h102, 32'h0, 32'h1234_5678, 0, 0, 0, -1));
        check_val("lhu_value", m_gpr_wr_data_o, 32'h0000_1234);
        run(mk(3, SIZE_HALF, 32'h101, 32'h0000_ABCD, 32'h0, 0, 0, 0, -1));
        run(mk(2, SIZE_WORD, 32'h200, 32'h0, 32'hCAFE_F00D, 2, 2, 0, -1));
        run(mk(2, SIZE_HALF, 32'h302, 32'h0, 32'h9876_5432, 0, 0, 2, -1));
        check_val("held_lh_value", m_gpr_wr_data_o, 32'hFFFF_9876);
        run(mk(3, SIZE_BYTE, 32'h402, 32'h0000_005A, 32'h0, 1, 1, 2, -1));
        run(mk(0, SIZE_WORD, 32'h0, 32'h0, 32'h0, 0, 0, 0, -1));
        run(mk(2, SIZE_WORD, 32'h500, 32'h0, 32'h1111_2222, 0, 2, 0, 1));
        run(mk(1, SIZE_WORD, 32'h0, 32'h0, 32'h0, 0, 0, 1, -1));

        // Randomized stream
        for (int i = 0; i < 200; i++) begin
            t = rand_instr();
            run(t);
        end

        // Reset while a request waits for grant
        t = mk(2, SIZE_WORD, 32'h600, 32'h0, 32'h0, 9, 0, 0, -1);
        e_valid_i = 1'b1; e_mem_req_i = 1'b1; e_mem_we_i = 1'b0;
        e_mem_size_i = SIZE_WORD; e_mem_addr_i = t.addr; e_gpr_src_sel_i = LSU_DATA;
        e_gpr_wr_en_i = 1'b1; data_gnt_i = 1'b0; data_rvalid_i = 1'b0; ext_stall = 1'b0;
        cu_kill_m_i = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_val("req_pending", {31'd0, data_req_o}, 32'd1);
        e_valid_i = 1'b0;
        arstn = 1'b0;
        #1;
        check_val("mid_rst_req", {31'd0, data_req_o}, 32'd0);
        check_val("mid_rst_stall", {31'd0, m_stall_req_o}, 32'd0);
        check_val("mid_rst_valid", {31'd0, m_valid_o}, 32'd0);
        @(posedge clk); #1;
        arstn = 1'b1;
        @(negedge clk);
        check_val("post_rst_stall", {31'd0, m_stall_req_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_miriscv_memory_stage
`default_nettype wire
